// File: rtl/cache_line_refill_if.sv
// Signal bundle between the miss-refill controller and its surroundings:
// miss request/status, line store read/write ports, memory read and write bursts.
interface cache_line_refill_if #(
  parameter int CACHE_LINE_WIDTH = 6,
  parameter int TAG_WIDTH        = 18
);
  localparam int OFFW = CACHE_LINE_WIDTH - 2;
  localparam int LAW  = 32 - CACHE_LINE_WIDTH;

  // Miss request and status
  logic                 miss_req;
  logic [LAW-1:0]       miss_line_addr;
  logic                 miss_wb;
  logic [LAW-1:0]       victim_line_addr;
  logic                 busy;
  logic                 done;
  logic                 err;

  // Line store ports
  logic [OFFW-1:0]      ln_rd_off;
  logic [31:0]          ln_rd_data;
  logic                 ln_wr_write;
  logic [TAG_WIDTH-1:0] ln_wr_tag;
  logic [OFFW-1:0]      ln_wr_off;
  logic [31:0]          ln_wr_data;
  logic [3:0]           ln_wr_byte_enable;
  logic                 ln_wr_dirty;
  logic                 ln_wr_valid;

  // Memory read burst
  logic                 mr_req_valid;
  logic                 mr_req_ready;
  logic [31:0]          mr_addr;
  logic                 mr_data_valid;
  logic [31:0]          mr_data;
  logic                 mr_data_last;

  // Memory write burst
  logic                 mw_req_valid;
  logic                 mw_req_ready;
  logic [31:0]          mw_addr;
  logic                 mw_data_valid;
  logic                 mw_data_ready;
  logic [31:0]          mw_data;
  logic                 mw_data_last;
  logic                 mw_resp_valid;

  // master: the refill controller
  modport master (
    input  miss_req, miss_line_addr, miss_wb, victim_line_addr,
    output busy, done, err,
    output ln_rd_off,
    input  ln_rd_data,
    output ln_wr_write, ln_wr_tag, ln_wr_off, ln_wr_data, ln_wr_byte_enable,
    output ln_wr_dirty, ln_wr_valid,
    output mr_req_valid, mr_addr,
    input  mr_req_ready, mr_data_valid, mr_data, mr_data_last,
    output mw_req_valid, mw_addr, mw_data_valid, mw_data, mw_data_last,
    input  mw_req_ready, mw_data_ready, mw_resp_valid
  );

  // slave: cache front end, line store and bus adapter
  modport slave (
    output miss_req, miss_line_addr, miss_wb, victim_line_addr,
    input  busy, done, err,
    input  ln_rd_off,
    output ln_rd_data,
    input  ln_wr_write, ln_wr_tag, ln_wr_off, ln_wr_data, ln_wr_byte_enable,
    input  ln_wr_dirty, ln_wr_valid,
    input  mr_req_valid, mr_addr,
    output mr_req_ready, mr_data_valid, mr_data, mr_data_last,
    input  mw_req_valid, mw_addr, mw_data_valid, mw_data, mw_data_last,
    output mw_req_ready, mw_data_ready, mw_resp_valid
  );
endinterface

// File: rtl/cache_line_refill.sv
// Cache line miss controller: optional dirty-victim write-back, then a line refill
// burst written word by word; tag/valid committed on the final beat.
// Write-back path present only when CACHE_WB_EN is defined.
//
// Handshakes: a valid output rises on its own and holds its payload unchanged until
// the matching ready is seen high at a clock edge; a transfer happens exactly on a
// cycle with valid && ready. Read beats (mr_data_valid) have no backpressure.
module cache_line_refill #(
  parameter int CACHE_LINE_WIDTH = 6,
  parameter int TAG_WIDTH        = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_line_refill_if.master   bus,
  output logic [2:0]            dbg_state_o
);
  localparam int OFFW = CACHE_LINE_WIDTH - 2;
  localparam int LAW  = 32 - CACHE_LINE_WIDTH;
  localparam logic [OFFW-1:0] LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_ADDR = 3'd1,
    S_WB_DATA = 3'd2,
    S_WB_RESP = 3'd3,
    S_RF_ADDR = 3'd4,
    S_RF_DATA = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [OFFW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [LAW-1:0]  miss_addr_q, miss_addr_d;
`ifdef CACHE_WB_EN
  logic [LAW-1:0]  victim_addr_q, victim_addr_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      miss_addr_q <= '0;
`ifdef CACHE_WB_EN
      victim_addr_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      miss_addr_q <= miss_addr_d;
`ifdef CACHE_WB_EN
      victim_addr_q <= victim_addr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    miss_addr_d = miss_addr_q;
`ifdef CACHE_WB_EN
    victim_addr_d = victim_addr_q;
`endif

    bus.busy              = (state_q != S_IDLE);
    bus.done              = 1'b0;
    bus.err               = err_q;
    bus.ln_rd_off         = cnt_q;
    bus.ln_wr_write       = 1'b0;
    bus.ln_wr_tag         = miss_addr_q[LAW-1 -: TAG_WIDTH];
    bus.ln_wr_off         = cnt_q;
    bus.ln_wr_data        = '0;
    bus.ln_wr_byte_enable = 4'hF;
    bus.ln_wr_dirty       = 1'b0;
    bus.ln_wr_valid       = 1'b0;
    bus.mr_req_valid      = 1'b0;
    bus.mr_addr           = {miss_addr_q, {CACHE_LINE_WIDTH{1'b0}}};
`ifdef CACHE_WB_EN
    bus.mw_req_valid      = 1'b0;
    bus.mw_addr           = {victim_addr_q, {CACHE_LINE_WIDTH{1'b0}}};
    bus.mw_data_valid     = 1'b0;
    bus.mw_data           = '0;
    bus.mw_data_last      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.miss_req) begin
          miss_addr_d = bus.miss_line_addr;
          err_d       = 1'b0;
          cnt_d       = '0;
`ifdef CACHE_WB_EN
          victim_addr_d = bus.victim_line_addr;
          state_d       = bus.miss_wb ? S_WB_ADDR : S_RF_ADDR;
`else
          state_d       = S_RF_ADDR;
`endif
        end
      end
`ifdef CACHE_WB_EN
      S_WB_ADDR: begin
        bus.mw_req_valid = 1'b1;
        if (bus.mw_req_ready) state_d = S_WB_DATA;
      end
      S_WB_DATA: begin
        bus.mw_data_valid = 1'b1;
        bus.mw_data       = bus.ln_rd_data;
        bus.mw_data_last  = (cnt_q == LAST);
        if (bus.mw_data_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_WB_RESP;
        end
      end
      S_WB_RESP: begin
        if (bus.mw_resp_valid) state_d = S_RF_ADDR;
      end
`endif
      S_RF_ADDR: begin
        bus.mr_req_valid = 1'b1;
        if (bus.mr_req_ready) state_d = S_RF_DATA;
      end
      S_RF_DATA: begin
        if (bus.mr_data_valid) begin
          bus.ln_wr_write = 1'b1;
          bus.ln_wr_data  = bus.mr_data;
          bus.ln_wr_valid = (cnt_q == LAST);
          // A misplaced last flag is only reported; the beat count still rules.
          if (bus.mr_data_last != (cnt_q == LAST)) err_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifndef CACHE_WB_EN
  // Write-through build: no write-back bus activity at all.
  assign bus.mw_req_valid  = 1'b0;
  assign bus.mw_addr       = '0;
  assign bus.mw_data_valid = 1'b0;
  assign bus.mw_data       = '0;
  assign bus.mw_data_last  = 1'b0;

  logic unused_wb;
  assign unused_wb = ^{bus.miss_wb, bus.victim_line_addr, bus.ln_rd_data,
                       bus.mw_req_ready, bus.mw_data_ready, bus.mw_resp_valid};
`endif

  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_cache_line_refill.sv
// Directed bench for cache_line_refill with a small line-store model.
module tb_cache_line_refill;
  logic clk;
  logic rst;
  logic [2:0] dbg_state;
  int checks;
  int errors;

  cache_line_refill_if #(.CACHE_LINE_WIDTH(6), .TAG_WIDTH(18)) bus ();

  cache_line_refill #(.CACHE_LINE_WIDTH(6), .TAG_WIDTH(18)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // line store model
  logic [31:0] line_data [16];
  logic        line_valid;
  logic [17:0] line_tag;

  assign bus.ln_rd_data = line_data[bus.ln_rd_off];

  always @(posedge clk) begin
    if (bus.ln_wr_write) begin
      line_data[bus.ln_wr_off] <= bus.ln_wr_data;
      if (bus.ln_wr_valid) begin
        line_valid <= 1'b1;
        line_tag   <= bus.ln_wr_tag;
      end
    end
  end

  // driver helpers
  task automatic idle_inputs();
    bus.miss_req         = 1'b0;
    bus.miss_line_addr   = '0;
    bus.miss_wb          = 1'b0;
    bus.victim_line_addr = '0;
    bus.mr_req_ready     = 1'b0;
    bus.mr_data_valid    = 1'b0;
    bus.mr_data          = '0;
    bus.mr_data_last     = 1'b0;
    bus.mw_req_ready     = 1'b0;
    bus.mw_data_ready    = 1'b0;
    bus.mw_resp_valid    = 1'b0;
  endtask

  task automatic start_miss(input logic [25:0] addr, input logic wb, input logic [25:0] victim);
    @(negedge clk);
    bus.miss_line_addr   = addr;
    bus.miss_wb          = wb;
    bus.victim_line_addr = victim;
    bus.miss_req         = 1'b1;
    @(negedge clk);
    bus.miss_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b err=%b state=%0d, want 0 0 0 0",
               bus.busy, bus.done, bus.err, dbg_state);
    end
    checks++;
    if (bus.ln_wr_write !== 1'b0 || bus.ln_wr_byte_enable !== 4'hF || bus.ln_rd_off !== 4'd0 ||
        bus.ln_wr_valid !== 1'b0 || bus.ln_wr_tag !== 18'd0) begin
      errors++;
      $display("FAIL reset_line: wr=%b be=%h rd_off=%0d valid=%b tag=%h, want 0 f 0 0 0",
               bus.ln_wr_write, bus.ln_wr_byte_enable, bus.ln_rd_off, bus.ln_wr_valid, bus.ln_wr_tag);
    end
    checks++;
    if (bus.mr_req_valid !== 1'b0 || bus.mr_addr !== 32'd0 || bus.mw_req_valid !== 1'b0 ||
        bus.mw_data_valid !== 1'b0 || bus.mw_addr !== 32'd0 || bus.mw_data_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: mr_v=%b mr_a=%h mw_v=%b mw_dv=%b mw_a=%h, want all 0",
               bus.mr_req_valid, bus.mr_addr, bus.mw_req_valid, bus.mw_data_valid, bus.mw_addr);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stray_beat();
    @(negedge clk);
    bus.mr_data_valid = 1'b1;
    bus.mr_data       = 32'hDEAD_BEEF;
    bus.mr_data_last  = 1'b1;
    #1;
    checks++;
    if (bus.ln_wr_write !== 1'b0) begin
      errors++;
      $display("FAIL stray_write: ln_wr_write=%b, want 0", bus.ln_wr_write);
    end
    @(negedge clk);
    bus.mr_data_valid = 1'b0;
    bus.mr_data_last  = 1'b0;
    #1;
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_err: err=%b busy=%b, want 0 0", bus.err, bus.busy);
    end
  endtask

  task automatic test_clean_miss();
    int bad;
    bus.mr_req_ready = 1'b1;
    line_valid = 1'b0;
    start_miss(26'h0123456, 1'b0, 26'h0);
    #1;
    checks++;
    if (bus.mr_req_valid !== 1'b1 || bus.mr_addr !== 32'h048D1580 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL clean_addr: mr_v=%b mr_addr=%h busy=%b, want 1 048d1580 1",
               bus.mr_req_valid, bus.mr_addr, bus.busy);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.mr_data_valid = 1'b1;
      bus.mr_data       = i;
      bus.mr_data_last  = (i == 15);
      #1;
      if (bus.ln_wr_write !== 1'b1 || bus.ln_wr_off !== 4'(i) || bus.ln_wr_data !== 32'(i) ||
          bus.ln_wr_valid !== (i == 15) || bus.ln_wr_tag !== 18'h01234 ||
          bus.ln_wr_dirty !== 1'b0 || bus.ln_wr_byte_enable !== 4'hF) begin
        bad++;
        $display("FAIL clean_beat %0d: wr=%b off=%0d data=%h valid=%b tag=%h, want 1 %0d %h %b 01234",
                 i, bus.ln_wr_write, bus.ln_wr_off, bus.ln_wr_data, bus.ln_wr_valid, bus.ln_wr_tag,
                 i, i, (i == 15));
      end
    end
    checks++;
    if (bad != 0) errors++;
    @(negedge clk);
    bus.mr_data_valid = 1'b0;
    bus.mr_data_last  = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.ln_wr_write !== 1'b0) begin
      errors++;
      $display("FAIL clean_done_cycle18: done=%b wr=%b, want 1 0", bus.done, bus.ln_wr_write);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL clean_after: done=%b busy=%b err=%b, want 0 0 0", bus.done, bus.busy, bus.err);
    end
    checks++;
    if (line_valid !== 1'b1 || line_tag !== 18'h01234 || line_data[0] !== 32'd0 ||
        line_data[9] !== 32'd9 || line_data[15] !== 32'd15) begin
      errors++;
      $display("FAIL clean_line: valid=%b tag=%h d0=%h d9=%h d15=%h, want 1 01234 0 9 f",
               line_valid, line_tag, line_data[0], line_data[9], line_data[15]);
    end
  endtask

  task automatic test_backpressure_rd();
    int bad;
    bus.mr_req_ready = 1'b0;
    start_miss(26'h0000001, 1'b0, 26'h0);
    bad = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 5) bus.mr_req_ready = 1'b1;
      #1;
      if (bus.mr_req_valid !== 1'b1 || bus.mr_addr !== 32'h0000_0040 || dbg_state !== 3'd4) begin
        bad++;
        $display("FAIL bp_req_stall %0d: mr_v=%b mr_addr=%h state=%0d, want 1 00000040 4",
                 k, bus.mr_req_valid, bus.mr_addr, dbg_state);
      end
    end
    checks++;
    if (bad != 0) errors++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.mr_data_valid = 1'b1;
      bus.mr_data       = 32'h100 + i;
      bus.mr_data_last  = (i == 15);
      #1;
      if (bus.ln_wr_write !== 1'b1 || bus.ln_wr_off !== 4'(i)) begin
        bad++;
        $display("FAIL bp_beat %0d: wr=%b off=%0d, want 1 %0d", i, bus.ln_wr_write, bus.ln_wr_off, i);
      end
      @(negedge clk);
      bus.mr_data_valid = 1'b0;
      bus.mr_data_last  = 1'b0;
      #1;
      if (bus.ln_wr_write !== 1'b0 || bus.done !== (i == 15)) begin
        bad++;
        $display("FAIL bp_gap %0d: wr=%b done=%b, want 0 %b", i, bus.ln_wr_write, bus.done, (i == 15));
      end
    end
    checks++;
    if (bad != 0) errors++;
    bad = 0;
    for (int i = 0; i < 16; i++) if (line_data[i] !== 32'h100 + i) bad++;
    checks++;
    if (bad != 0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL bp_line: %0d wrong words, err=%b, want 0 0", bad, bus.err);
    end
  endtask

  task automatic test_short_burst();
    bus.mr_req_ready = 1'b1;
    start_miss(26'h0000200, 1'b0, 26'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.mr_data_valid = 1'b1;
      bus.mr_data       = 32'h200 + i;
      bus.mr_data_last  = (i == 7);
      #1;
      if (i == 8) begin
        checks++;
        if (bus.err !== 1'b1 || bus.ln_wr_write !== 1'b1 || bus.ln_wr_off !== 4'd8) begin
          errors++;
          $display("FAIL short_err_set: err=%b wr=%b off=%0d, want 1 1 8",
                   bus.err, bus.ln_wr_write, bus.ln_wr_off);
        end
      end
    end
    @(negedge clk);
    bus.mr_data_valid = 1'b0;
    bus.mr_data_last  = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b1 || line_data[15] !== 32'h20F) begin
      errors++;
      $display("FAIL short_done: done=%b err=%b d15=%h, want 1 1 20f", bus.done, bus.err, line_data[15]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL short_sticky: err=%b, want 1", bus.err);
    end
    start_miss(26'h0000300, 1'b0, 26'h0);
    #1;
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL short_clear: err=%b, want 0", bus.err);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.mr_data_valid = 1'b1;
      bus.mr_data       = i;
      bus.mr_data_last  = (i == 15);
    end
    @(negedge clk);
    bus.mr_data_valid = 1'b0;
    bus.mr_data_last  = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL short_next: done=%b err=%b, want 1 0", bus.done, bus.err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    line_valid = 1'b0;
    bus.mr_req_ready = 1'b1;
    start_miss(26'h0000400, 1'b0, 26'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.mr_data_valid = 1'b1;
      bus.mr_data       = i;
      bus.mr_data_last  = 1'b0;
      if (i == 9) rst = 1'b0;
    end
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.ln_wr_write !== 1'b0 || bus.ln_rd_off !== 4'd0 ||
        bus.mr_addr !== 32'd0 || bus.ln_wr_tag !== 18'd0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%b wr=%b off=%0d mr_addr=%h tag=%h state=%0d, want 0 0 0 0 0 0",
               bus.busy, bus.ln_wr_write, bus.ln_rd_off, bus.mr_addr, bus.ln_wr_tag, dbg_state);
    end
    @(negedge clk);
    bus.mr_data_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (line_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_line: valid=%b busy=%b, want 0 0", line_valid, bus.busy);
    end
    start_miss(26'h3FFFFFF, 1'b0, 26'h0);
    #1;
    checks++;
    if (bus.mr_addr !== 32'hFFFF_FFC0 || bus.mr_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_addr: mr_addr=%h mr_v=%b, want ffffffc0 1", bus.mr_addr, bus.mr_req_valid);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.mr_data_valid = 1'b1;
      bus.mr_data       = 32'hC0 + i;
      bus.mr_data_last  = (i == 15);
    end
    @(negedge clk);
    bus.mr_data_valid = 1'b0;
    bus.mr_data_last  = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b1 || line_valid !== 1'b1 || line_tag !== 18'h3FFFF || line_data[9] !== 32'hC9) begin
      errors++;
      $display("FAIL midrst_next: done=%b valid=%b tag=%h d9=%h, want 1 1 3ffff c9",
               bus.done, line_valid, line_tag, line_data[9]);
    end
    @(negedge clk);
  endtask

`ifdef CACHE_WB_EN
  task automatic test_dirty_miss();
    int beat;
    int cyc;
    int bad;
    for (int i = 0; i < 16; i++) line_data[i] = 32'hA0 + i;
    bus.mw_req_ready  = 1'b1;
    bus.mr_req_ready  = 1'b1;
    bus.mw_resp_valid = 1'b0;
    start_miss(26'h0000020, 1'b1, 26'h0000010);
    #1;
    checks++;
    if (bus.mw_req_valid !== 1'b1 || bus.mw_addr !== 32'h0000_0400 || bus.mr_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL dirty_addr: mw_v=%b mw_addr=%h mr_v=%b, want 1 00000400 0",
               bus.mw_req_valid, bus.mw_addr, bus.mr_req_valid);
    end
    beat = 0;
    cyc  = 0;
    bad  = 0;
    while (beat < 16 && cyc < 64) begin
      @(negedge clk);
      bus.mw_data_ready = cyc[0];
      cyc++;
      #1;
      if (bus.mw_data_valid !== 1'b1 || bus.mw_data !== 32'hA0 + beat ||
          bus.mw_data_last !== (beat == 15)) begin
        bad++;
        $display("FAIL dirty_beat %0d: dv=%b data=%h last=%b, want 1 %h %b",
                 beat, bus.mw_data_valid, bus.mw_data, bus.mw_data_last, 32'hA0 + beat, (beat == 15));
      end
      if (bus.mw_data_ready) beat++;
    end
    checks++;
    if (bad != 0 || beat != 16) begin
      errors++;
      $display("FAIL dirty_beats: %0d bad, %0d accepted, want 0 16", bad, beat);
    end
    bus.mw_data_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (bus.mr_req_valid !== 1'b0 || bus.mw_data_valid !== 1'b0 || dbg_state !== 3'd3) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL dirty_resp_wait: %0d cycles wrong, want 0", bad);
    end
    bus.mw_resp_valid = 1'b1;
    @(negedge clk);
    bus.mw_resp_valid = 1'b0;
    #1;
    checks++;
    if (bus.mr_req_valid !== 1'b1 || bus.mr_addr !== 32'h0000_0800) begin
      errors++;
      $display("FAIL dirty_refill: mr_v=%b mr_addr=%h, want 1 00000800", bus.mr_req_valid, bus.mr_addr);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.mr_data_valid = 1'b1;
      bus.mr_data       = 32'hB0 + i;
      bus.mr_data_last  = (i == 15);
    end
    @(negedge clk);
    bus.mr_data_valid = 1'b0;
    bus.mr_data_last  = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b1 || line_data[0] !== 32'hB0 || line_data[15] !== 32'hBF) begin
      errors++;
      $display("FAIL dirty_done: done=%b d0=%h d15=%h, want 1 b0 bf", bus.done, line_data[0], line_data[15]);
    end
    @(negedge clk);
  endtask
`else
  task automatic test_no_wb();
    int bad;
    bus.mr_req_ready = 1'b1;
    bus.mw_req_ready = 1'b1;
    bus.mw_data_ready = 1'b1;
    start_miss(26'h0000020, 1'b1, 26'h0000010);
    #1;
    checks++;
    if (dbg_state !== 3'd4 || bus.mr_req_valid !== 1'b1 || bus.mr_addr !== 32'h0000_0800) begin
      errors++;
      $display("FAIL nowb_direct: state=%0d mr_v=%b mr_addr=%h, want 4 1 00000800",
               dbg_state, bus.mr_req_valid, bus.mr_addr);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.mr_data_valid = 1'b1;
      bus.mr_data       = 32'hB0 + i;
      bus.mr_data_last  = (i == 15);
      #1;
      if (bus.mw_req_valid !== 1'b0 || bus.mw_data_valid !== 1'b0 || bus.mw_addr !== 32'd0 ||
          bus.mw_data !== 32'd0 || bus.mw_data_last !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nowb_mw_quiet: %0d cycles with mw activity, want 0", bad);
    end
    @(negedge clk);
    bus.mr_data_valid = 1'b0;
    bus.mr_data_last  = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b1 || line_data[15] !== 32'hBF) begin
      errors++;
      $display("FAIL nowb_done: done=%b d15=%h, want 1 bf", bus.done, line_data[15]);
    end
    @(negedge clk);
    bus.mw_req_ready  = 1'b0;
    bus.mw_data_ready = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    line_valid = 1'b0;
    line_tag   = '0;
    for (int i = 0; i < 16; i++) line_data[i] = '0;
    test_reset();
    test_stray_beat();
    test_clean_miss();
    test_backpressure_rd();
    test_short_burst();
    test_reset_mid();
`ifdef CACHE_WB_EN
    test_dirty_miss();
`else
    test_no_wb();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
